fx_pt_acc_rnd_sat: RTL and testbench

FX_PT_ACC_RND_SAT -- requirements
Module: fx_pt_acc_rnd_sat

---
 rtl/fx_pt_acc_rnd_sat.sv | 155 +++++++++++++++
 tb/tb_fx_pt_acc_rnd_sat.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fx_pt_acc_rnd_sat.sv
// fx_pt_acc_rnd_sat: frame accumulator with rounding and range handling.
// It accumulates up to N fixed-point samples per frame, exactly, in two's
// complement. A frame closes on the N-th accepted sample or on in_last. The
// sum is rounded half away from zero to OFW fraction bits, range-checked
// against the OIW.OFW output format, and handed out on a valid/ready port.
// Number format SN: 0 unsigned, 1 two's complement, 2 sign-magnitude.
// Optional macro FX_ACC_SAT_EN: out-of-range results clamp to the range limit.
// When the macro is not defined, out-of-range results wrap.
module fx_pt_acc_rnd_sat #(
    parameter int SN  = 1,
    parameter int IW  = 4,
    parameter int FW  = 8,
    parameter int OIW = 8,
    parameter int OFW = 3,
    parameter int N   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [IW+FW-1:0]   in_data,
    input  logic               in_last,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [OIW+OFW-1:0] out_data,
    output logic               out_ovf
);

    localparam int IN_W    = IW + FW;
    localparam int W       = OIW + OFW;
    localparam int CW      = (N > 1) ? $clog2(N) : 1;
    localparam int AW      = IN_W + $clog2(N) + 1;
    localparam int DROP    = (OFW < FW) ? FW - OFW : 0;
    localparam int PAD     = (OFW >= FW) ? OFW - FW : 0;
    localparam int DROP_M1 = (DROP > 0) ? DROP - 1 : 0;
    // Rounded result width: wide enough for the padded sum and the output
    // range, plus headroom so that range compares never alias.
    localparam int RW      = (((AW + PAD) > W) ? (AW + PAD) : W) + 2;

    localparam logic signed [RW-1:0] ONE    = RW'(1);
    localparam logic        [RW-1:0] HALF   = RW'(1) << DROP_M1;
    localparam logic signed [RW-1:0] LIM_HI = (SN == 0) ? (ONE <<< W) - ONE
                                                        : (ONE <<< (W-1)) - ONE;
    localparam logic signed [RW-1:0] LIM_LO = (SN == 0) ? RW'(0)
                                            : (SN == 1) ? -(ONE <<< (W-1))
                                                        : -LIM_HI;

    typedef enum logic [0:0] {ACC, OUT} state_t;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;

    logic signed [AW-1:0] sum_nxt;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] res;
    logic                 ovf_nxt;
    logic [W-1:0]         enc_nxt;
    logic                 closing;

    // Input sample in SN format -> sign-correct accumulator-width value.
    function automatic logic signed [AW-1:0] to_acc(input logic [IN_W-1:0] d);
        logic [AW-1:0] mag;
        mag = '0;
        if (SN == 0) begin
            return {{(AW-IN_W){1'b0}}, d};
        end else if (SN == 1) begin
            return {{(AW-IN_W){d[IN_W-1]}}, d};
        end else begin
            mag = {{(AW-IN_W+1){1'b0}}, d[IN_W-2:0]};
            return d[IN_W-1] ? $signed(~mag + 1'b1) : $signed(mag);
        end
    endfunction

    // Work on the magnitude so that a tie rounds away from zero for either
    // sign. Then put the sign back. When there are no bits to drop, the
    // value is scaled up exactly.
    function automatic logic signed [RW-1:0] round_acc(input logic signed [AW-1:0] a);
        logic [RW-1:0] ax;
        logic [RW-1:0] mag;
        ax  = {{(RW-AW){a[AW-1]}}, a};
        mag = ax[RW-1] ? (~ax + 1'b1) : ax;
        if (DROP > 0) mag = (mag + HALF) >> DROP;
        else          mag = mag << PAD;
        return ax[RW-1] ? $signed(~mag + 1'b1) : $signed(mag);
    endfunction

    // Wide signed result -> output SN bit pattern. For sign-magnitude output,
    // the magnitude is truncated to its low bits and the sign is kept. A zero
    // magnitude is always emitted as +0.
    function automatic logic [W-1:0] encode(input logic signed [RW-1:0] v);
        logic [W-2:0] ml;
        logic [W-1:0] o;
        ml = v[RW-1] ? (~v[W-2:0] + 1'b1) : v[W-2:0];
        if (SN == 2) o = {(v[RW-1] && (ml != '0)), ml};
        else         o = v[W-1:0];
        return o;
    endfunction

    // Result path for the sample being accepted this cycle. It is used only
    // when that sample closes the frame.
    always_comb begin
        sum_nxt = acc + to_acc(in_data);
        rnd     = round_acc(sum_nxt);
        ovf_nxt = (rnd > LIM_HI) || (rnd < LIM_LO);
        res     = rnd;
`ifdef FX_ACC_SAT_EN
        if (ovf_nxt) res = rnd[RW-1] ? LIM_LO : LIM_HI;
`endif
        enc_nxt = encode(res);
        closing = in_last || (cnt == CW'(N-1));
    end

    // Two-state frame FSM: accumulate samples, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            cnt      <= '0;
            in_rdy   <= 1'b1;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_vld) begin
                        if (closing) begin
                            acc      <= '0;
                            cnt      <= '0;
                            out_data <= enc_nxt;
                            out_ovf  <= ovf_nxt;
                            out_vld  <= 1'b1;
                            in_rdy   <= 1'b0;
                            state    <= OUT;
                        end else begin
                            acc <= sum_nxt;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        acc     <= '0;
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_pt_acc_rnd_sat.sv
// Bench for fx_pt_acc_rnd_sat with the default build parameters:
// SN=1, IW=4, FW=8, OIW=8, OFW=3, N=16.
// A spec-level model computes frame sums with integer arithmetic. One
// compare process checks the DUT against that model on every cycle.
// Directed frames also pin the expected values by hand.
module tb_fx_pt_acc_rnd_sat;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, in_rdy, in_last;
    logic [11:0] in_data;
    logic        out_vld, out_rdy, out_ovf;
    logic [10:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    fx_pt_acc_rnd_sat #(.SN(1), .IW(4), .FW(8), .OIW(8), .OFW(3), .N(16)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Frame sum (in units of 2^-8) -> expected output code and overflow flag.
    function automatic void model_res(input longint sum, output logic [10:0] d, output logic o);
        longint mag;
        longint r;
        mag = (sum < 0) ? -sum : sum;
        mag = (mag + 16) / 32;
        r   = (sum < 0) ? -mag : mag;
        o   = (r > 1023) || (r < -1024);
`ifdef FX_ACC_SAT_EN
        if (r > 1023) r = 1023;
        else if (r < -1024) r = -1024;
`endif
        d = r[10:0];
    endfunction

    typedef struct { logic [10:0] d; logic o; } res_t;
    res_t   q[$];
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     pend = 0, held = 0;
    logic [10:0] hd;
    logic        ho;

    // Compare process: inputs and outputs are stable 1 time unit after
    // negedge, and they describe what happens at the next posedge.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                q.delete();
                m_sum = 0; m_cnt = 0; pend = 0; held = 0;
            end else begin
                chk("rdy_vs_vld", {31'd0, in_rdy}, {31'd0, !out_vld});
                if (pend) begin
                    chk("latency_out_vld", {31'd0, out_vld}, 32'd1);
                    pend = 0;
                end
                if (held) begin
                    chk("hold_data", {21'd0, out_data}, {21'd0, hd});
                    chk("hold_ovf", {31'd0, out_ovf}, {31'd0, ho});
                end
                held = out_vld && !out_rdy;
                hd = out_data; ho = out_ovf;
                if (out_vld && out_rdy) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
                    end else begin
                        r = q.pop_front();
                        chk("model_data", {21'd0, out_data}, {21'd0, r.d});
                        chk("model_ovf", {31'd0, out_ovf}, {31'd0, r.o});
                    end
                end
                if (in_vld && in_rdy) begin
                    m_sum += longint'($signed(in_data));
                    m_cnt++;
                    if (m_cnt == 16 || in_last) begin
                        model_res(m_sum, r.d, r.o);
                        q.push_back(r);
                        m_sum = 0; m_cnt = 0; pend = 1;
                    end
                end
            end
        end
    end

    task automatic send_n(input int n, input logic [11:0] d, input bit last_on_final);
        int t;
        for (int i = 0; i < n; i++) begin
            in_vld  = 1'b1;
            in_data = d;
            in_last = last_on_final && (i == n-1);
            t = 0;
            while (!in_rdy && t < 50) begin @(negedge clk); t++; end
            if (!in_rdy) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: got in_rdy=0 expected 1");
            end
            @(negedge clk);
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_vld();
        int t;
        t = 0;
        while (!out_vld && t < 40) begin @(negedge clk); t++; end
        if (!out_vld) begin
            n_cmp++; n_err++;
            $display("FAIL out_vld_timeout: got out_vld=0 expected 1");
        end
    endtask

    task automatic expect_res(input string nm, input logic [10:0] d, input logic o);
        wait_vld();
        chk({nm, "_data"}, {21'd0, out_data}, {21'd0, d});
        chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_last = 1'b0; in_data = '0; out_rdy = 1'b0;
        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_data", {21'd0, out_data}, 32'h000);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);

        // 16 x 1.0 = 16.0
        send_n(16, 12'h100, 1'b0);
        expect_res("full_frame", 11'h080, 1'b0);

        // Half-LSB ties round away from zero.
        send_n(1, 12'h010, 1'b1);
        expect_res("tie_pos", 11'h001, 1'b0);
        send_n(1, 12'hFF0, 1'b1);
        expect_res("tie_neg", 11'h7FF, 1'b0);
        // -1.5 LSB -> -2 LSB
        send_n(1, 12'hFD0, 1'b1);
        expect_res("neg_1p5", 11'h7FE, 1'b0);

        // Overflow: 1023.5 LSB rounds to 1024.
        send_n(16, 12'h7FF, 1'b0);
`ifdef FX_ACC_SAT_EN
        expect_res("ovf", 11'h3FF, 1'b1);
`else
        expect_res("ovf", 11'h400, 1'b1);
`endif

        // Back-pressure: result holds and no samples are taken.
        send_n(16, 12'h100, 1'b0);
        wait_vld();
        in_vld = 1'b1; in_data = 12'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_rdy", {31'd0, in_rdy}, 32'd0);
            chk("stall_data", {21'd0, out_data}, 32'h080);
        end
        expect_res("stall", 11'h080, 1'b0);
        send_n(16, 12'h200, 1'b0);
        expect_res("after_stall", 11'h100, 1'b0);

        // in_last on the 16th sample closes exactly one frame.
        send_n(16, 12'h080, 1'b1);
        expect_res("last_at_n", 11'h040, 1'b0);
        repeat (4) @(negedge clk);
        chk("no_empty_frame", {31'd0, out_vld}, 32'd0);

        // Reset mid-frame discards the partial sum.
        send_n(7, 12'h100, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_n(16, 12'h100, 1'b0);
        expect_res("post_rst", 11'h080, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
